// File: rtl/axi_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_responder_pkg
// Description : Shared AXI constants and FSM state encodings for the AXI4
//               slave memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_mem_responder_pkg;

  // AXI field widths
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;
  localparam int AXI_RESP_W = 2;

  // AXI response codes
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;

  // AXI burst types (all serviced with INCR behaviour)
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // Write FSM encoding
  localparam int         W_ST_W = 2;
  localparam logic [W_ST_W-1:0] W_IDLE = 2'd0;
  localparam logic [W_ST_W-1:0] W_DATA = 2'd1;
  localparam logic [W_ST_W-1:0] W_RESP = 2'd2;

  // Read FSM encoding
  localparam int         R_ST_W = 2;
  localparam logic [R_ST_W-1:0] R_IDLE  = 2'd0;
  localparam logic [R_ST_W-1:0] R_FETCH = 2'd1;
  localparam logic [R_ST_W-1:0] R_DATA  = 2'd2;

  // Map an error flag onto the AXI response code
  function automatic logic [AXI_RESP_W-1:0] resp_of(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_responder_if
// Description : AXI4 bus bundle (AW/W/B/AR/R) with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_mem_responder_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  // Write address channel
  logic              awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;
  // Write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // Write response channel
  logic       bid;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;
  // Read address channel
  logic              arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;
  // Read data channel
  logic              rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface
`default_nettype wire

// File: rtl/axi_mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_responder_ram
// Description : Simple dual-port RAM: one byte-enabled write port and one
//               read port with a single-cycle registered output.
//               A same-cycle read of the word being written returns old data.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_responder_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                we,
  input  wire logic [ADDR_W-1:0]   waddr,
  input  wire logic [DATA_W-1:0]   wdata,
  input  wire logic [DATA_W/8-1:0] wstrb,
  input  wire logic                re,
  input  wire logic [ADDR_W-1:0]   raddr,
  output logic      [DATA_W-1:0]   rdata
);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write; storage is never reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read data only moves when a read is issued, so it holds for the consumer
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Registered read output
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_responder
// Description : AXI4 slave memory. Independent write (AW/W/B) and read (AR/R)
//               FSMs, one outstanding burst each, serviced from an internal
//               dual-port RAM. Bad transfer size or burst-length mismatch
//               answers SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 16
) (
  input wire logic          clk,
  input wire logic          reset,
  axi_mem_responder_if.slave s_axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [AXI_SIZE_W-1:0] FULL_SIZE = AXI_SIZE_W'(OFF_W);

  // Write-side state
  logic [W_ST_W-1:0]     w_state_q,    w_state_d;
  logic                  w_id_q,       w_id_d;
  logic [MEM_ADDR_W-1:0] w_addr_q,     w_addr_d;
  logic [AXI_LEN_W-1:0]  w_len_q,      w_len_d;
  logic [AXI_LEN_W-1:0]  w_cnt_q,      w_cnt_d;
  logic                  w_size_err_q, w_size_err_d;
  logic                  w_prot_err_q, w_prot_err_d;
  logic                  w_over_q,     w_over_d;

  // Read-side state
  logic [R_ST_W-1:0]     r_state_q,    r_state_d;
  logic                  r_id_q,       r_id_d;
  logic [MEM_ADDR_W-1:0] r_addr_q,     r_addr_d;
  logic [AXI_LEN_W-1:0]  r_len_q,      r_len_d;
  logic [AXI_LEN_W-1:0]  r_cnt_q,      r_cnt_d;
  logic                  r_size_err_q, r_size_err_d;

  // RAM hookup and channel outputs
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              aw_ready, w_ready, b_valid, b_id;
  logic [1:0]        b_resp;
  logic              ar_ready, r_valid, r_last, r_id;
  logic [1:0]        r_resp;

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q    <= W_IDLE;
      w_id_q       <= 1'b0;
      w_addr_q     <= '0;
      w_len_q      <= '0;
      w_cnt_q      <= '0;
      w_size_err_q <= 1'b0;
      w_prot_err_q <= 1'b0;
      w_over_q     <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      w_id_q       <= w_id_d;
      w_addr_q     <= w_addr_d;
      w_len_q      <= w_len_d;
      w_cnt_q      <= w_cnt_d;
      w_size_err_q <= w_size_err_d;
      w_prot_err_q <= w_prot_err_d;
      w_over_q     <= w_over_d;
    end
  end

  // Write FSM next state: latch burst on AW, track beats, flag length mismatch
  always_comb begin
    w_state_d    = w_state_q;
    w_id_d       = w_id_q;
    w_addr_d     = w_addr_q;
    w_len_d      = w_len_q;
    w_cnt_d      = w_cnt_q;
    w_size_err_d = w_size_err_q;
    w_prot_err_d = w_prot_err_q;
    w_over_d     = w_over_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid) begin
          w_state_d    = W_DATA;
          w_id_d       = s_axi.awid;
          w_addr_d     = s_axi.awaddr[MEM_ADDR_W+OFF_W-1:OFF_W];
          w_len_d      = s_axi.awlen;
          w_cnt_d      = '0;
          w_size_err_d = (s_axi.awsize != FULL_SIZE);
          w_prot_err_d = 1'b0;
          w_over_d     = 1'b0;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid) begin
          w_cnt_d  = w_cnt_q + 1'b1;
          w_addr_d = w_addr_q + 1'b1;
          // Last expected beat without wlast: later beats are dropped
          if ((w_cnt_q == w_len_q) && !s_axi.wlast) begin
            w_prot_err_d = 1'b1;
            w_over_d     = 1'b1;
          end
          if (s_axi.wlast && ((w_cnt_q != w_len_q) || w_over_q)) begin
            w_prot_err_d = 1'b1;
          end
          if (s_axi.wlast) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs
  always_comb begin
    aw_ready = (w_state_q == W_IDLE);
    w_ready  = (w_state_q == W_DATA);
    b_valid  = (w_state_q == W_RESP);
    b_id     = w_id_q;
    b_resp   = resp_of(w_size_err_q | w_prot_err_q);
    ram_we   = (w_state_q == W_DATA) && s_axi.wvalid && !w_size_err_q && !w_over_q && !reset;
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q    <= R_IDLE;
      r_id_q       <= 1'b0;
      r_addr_q     <= '0;
      r_len_q      <= '0;
      r_cnt_q      <= '0;
      r_size_err_q <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      r_id_q       <= r_id_d;
      r_addr_q     <= r_addr_d;
      r_len_q      <= r_len_d;
      r_cnt_q      <= r_cnt_d;
      r_size_err_q <= r_size_err_d;
    end
  end

  // Read FSM next state: fetch one word, present it, advance on acceptance
  always_comb begin
    r_state_d    = r_state_q;
    r_id_d       = r_id_q;
    r_addr_d     = r_addr_q;
    r_len_d      = r_len_q;
    r_cnt_d      = r_cnt_q;
    r_size_err_d = r_size_err_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid) begin
          r_state_d    = R_FETCH;
          r_id_d       = s_axi.arid;
          r_addr_d     = s_axi.araddr[MEM_ADDR_W+OFF_W-1:OFF_W];
          r_len_d      = s_axi.arlen;
          r_cnt_d      = '0;
          r_size_err_d = (s_axi.arsize != FULL_SIZE);
        end
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        if (s_axi.rready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d  = r_addr_q + 1'b1;
            r_cnt_d   = r_cnt_q + 1'b1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    ar_ready = (r_state_q == R_IDLE);
    r_valid  = (r_state_q == R_DATA);
    r_last   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
    r_id     = r_id_q;
    r_resp   = resp_of(r_size_err_q);
    ram_re   = (r_state_q == R_FETCH);
  end

  axi_mem_responder_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (w_addr_q),
    .wdata (s_axi.wdata),
    .wstrb (s_axi.wstrb),
    .re    (ram_re),
    .raddr (r_addr_q),
    .rdata (ram_rdata)
  );

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.bvalid  = b_valid;
  assign s_axi.bid     = b_id;
  assign s_axi.bresp   = b_resp;
  assign s_axi.arready = ar_ready;
  assign s_axi.rvalid  = r_valid;
  assign s_axi.rlast   = r_last;
  assign s_axi.rid     = r_id;
  assign s_axi.rresp   = r_resp;
  assign s_axi.rdata   = ram_rdata;

  // Address bits outside the RAM window and the attribute fields carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{s_axi.awaddr[ADDR_W-1:MEM_ADDR_W+OFF_W], s_axi.awaddr[OFF_W-1:0],
                       s_axi.araddr[ADDR_W-1:MEM_ADDR_W+OFF_W], s_axi.araddr[OFF_W-1:0],
                       s_axi.awburst, s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                       s_axi.arburst, s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axi_mem_responder
// Description : Self-checking bench for axi_mem_responder with a word-level
//               memory model tracking which bytes hold known data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_responder;
  import axi_mem_responder_pkg::*;

  localparam int ADDR_W     = 30;
  localparam int DATA_W     = 32;
  localparam int MEM_ADDR_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_axi ();

  axi_mem_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s_axi (s_axi)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference memory: word contents plus per-byte "known" mask
  logic [31:0] model [int];
  logic [3:0]  known [int];

  logic [31:0] wd [0:255];
  logic [3:0]  ws [0:255];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int word_idx(input logic [29:0] addr, input int beat);
    return int'(((addr >> 2) + 30'(beat)) & 30'hFFFF);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  task automatic wait_ready(input string tag, ref logic rdy);
    int n = 0;
    while (rdy !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(n < 50), 64'd1);
  endtask

  task automatic axi_write(input logic id, input logic [29:0] addr, input int len,
                           input logic [2:0] size, input int nbeats, input int bdelay);
    logic        err;
    logic [1:0]  exp_resp;
    logic [31:0] m;
    int          idx;
    s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = 8'(len);
    s_axi.awsize = size; s_axi.awburst = AXI_BURST_INCR; s_axi.awvalid = 1'b1;
    wait_ready("aw_wait", s_axi.awready);
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0;
    check("wready_latency", 64'(s_axi.wready), 64'd1);
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(3) == 0) begin
        s_axi.wvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axi.wvalid = 1'b1; s_axi.wdata = wd[i]; s_axi.wstrb = ws[i];
      s_axi.wlast = (i == nbeats - 1);
      wait_ready("w_wait", s_axi.wready);
      @(posedge clk); #1;
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    err = (size != 3'd2) || (nbeats != len + 1);
    exp_resp = err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    check("bvalid_latency", 64'(s_axi.bvalid), 64'd1);
    check("bresp", 64'(s_axi.bresp), 64'(exp_resp));
    check("bid", 64'(s_axi.bid), 64'(id));
    for (int k = 0; k < bdelay; k++) begin
      @(posedge clk); #1;
      check("b_hold", 64'({s_axi.bvalid, s_axi.bresp, s_axi.bid}), 64'({1'b1, exp_resp, id}));
    end
    s_axi.bready = 1'b1;
    @(posedge clk); #1;
    s_axi.bready = 1'b0;
    check("bvalid_drop", 64'(s_axi.bvalid), 64'd0);
    check("awready_back", 64'(s_axi.awready), 64'd1);
    if (size == 3'd2) begin
      for (int i = 0; i < nbeats && i <= len; i++) begin
        idx = word_idx(addr, i);
        if (!model.exists(idx)) begin model[idx] = '0; known[idx] = '0; end
        m = lane_mask(ws[i]);
        model[idx] = (model[idx] & ~m) | (wd[i] & m);
        known[idx] = known[idx] | ws[i];
      end
    end
  endtask

  task automatic axi_read(input logic id, input logic [29:0] addr, input int len,
                          input logic [2:0] size, input bit stop_after_one);
    logic [31:0] snap, m;
    logic [1:0]  exp_resp;
    int          idx, hold;
    exp_resp = (size != 3'd2) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = 8'(len);
    s_axi.arsize = size; s_axi.arburst = AXI_BURST_INCR; s_axi.arvalid = 1'b1;
    wait_ready("ar_wait", s_axi.arready);
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    check("r_fetch_gap", 64'(s_axi.rvalid), 64'd0);
    @(posedge clk); #1;
    check("rvalid_latency", 64'(s_axi.rvalid), 64'd1);
    for (int beat = 0; beat <= len; beat++) begin
      wait_ready("r_wait", s_axi.rvalid);
      snap = s_axi.rdata;
      hold = $urandom_range(3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("r_hold", 64'({s_axi.rvalid, s_axi.rdata}), 64'({1'b1, snap}));
      end
      idx = word_idx(addr, beat);
      if (size == 3'd2 && known.exists(idx) && known[idx] != 4'h0) begin
        m = lane_mask(known[idx]);
        check("rdata", 64'(s_axi.rdata & m), 64'(model[idx] & m));
      end
      check("rlast", 64'(s_axi.rlast), 64'(beat == len));
      check("rresp", 64'(s_axi.rresp), 64'(exp_resp));
      check("rid", 64'(s_axi.rid), 64'(id));
      last_rdata = s_axi.rdata;
      s_axi.rready = 1'b1;
      @(posedge clk); #1;
      s_axi.rready = 1'b0;
      if (stop_after_one) return;
    end
    check("arready_back", 64'(s_axi.arready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [29:0] a;
    int          len, nb;
    s_axi.awid = 0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0; s_axi.awburst = '0;
    s_axi.awlock = 0; s_axi.awcache = '0; s_axi.awprot = '0; s_axi.awqos = '0; s_axi.awvalid = 0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 0; s_axi.wvalid = 0; s_axi.bready = 0;
    s_axi.arid = 0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = '0; s_axi.arburst = '0;
    s_axi.arlock = 0; s_axi.arcache = '0; s_axi.arprot = '0; s_axi.arqos = '0; s_axi.arvalid = 0;
    s_axi.rready = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(s_axi.awready), 64'd1);
    check("rst_arready", 64'(s_axi.arready), 64'd1);
    check("rst_wready",  64'(s_axi.wready),  64'd0);
    check("rst_bvalid",  64'(s_axi.bvalid),  64'd0);
    check("rst_rvalid",  64'(s_axi.rvalid),  64'd0);
    check("rst_rlast",   64'(s_axi.rlast),   64'd0);
    check("rst_resp",    64'({s_axi.bresp, s_axi.rresp}), 64'd0);
    check("rst_ids",     64'({s_axi.bid, s_axi.rid}), 64'd0);
    check("rst_rdata",   64'(s_axi.rdata),   64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single-beat write and read-back
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(1'b1, 30'h10, 0, 3'd2, 1, 0);
    axi_read(1'b1, 30'h10, 0, 3'd2, 1'b0);
    check("single_const", 64'(last_rdata), 64'hDEADBEEF);

    // Four-beat burst with B backpressure
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_write(1'b0, 30'h100, 3, 3'd2, 4, 10);
    axi_read(1'b0, 30'h100, 3, 3'd2, 1'b0);
    check("burst_last_const", 64'(last_rdata), 64'd4);

    // Byte strobes
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    axi_write(1'b0, 30'h200, 0, 3'd2, 1, 0);
    wd[0] = 32'h00000000; ws[0] = 4'b0101;
    axi_write(1'b1, 30'h200, 0, 3'd2, 1, 2);
    axi_read(1'b0, 30'h200, 0, 3'd2, 1'b0);
    check("strobe_const", 64'(last_rdata), 64'hFF00FF00);

    // Wrong size: SLVERR, memory untouched
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    axi_write(1'b0, 30'h200, 0, 3'd1, 1, 0);
    axi_read(1'b1, 30'h200, 0, 3'd2, 1'b0);
    check("size_err_untouched", 64'(last_rdata), 64'hFF00FF00);
    axi_read(1'b1, 30'h100, 1, 3'd1, 1'b0);

    // Early wlast (beat 2 of 4) and late wlast (4 beats for len 1)
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000 + 32'(i); ws[i] = 4'hF; end
    axi_write(1'b0, 30'h300, 3, 3'd2, 2, 0);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hB000 + 32'(i); ws[i] = 4'hF; end
    axi_write(1'b1, 30'h400, 3, 3'd2, 4, 0);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC000 + 32'(i); ws[i] = 4'hF; end
    axi_write(1'b1, 30'h400, 1, 3'd2, 4, 0);
    axi_read(1'b0, 30'h400, 3, 3'd2, 1'b0);
    check("late_wlast_tail", 64'(last_rdata), 64'hB003);

    // Word index wraps at the top of the RAM
    wd[0] = 32'h0BAD_F00D; wd[1] = 32'h600D_CAFE; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(1'b0, 30'h3FFFC, 1, 3'd2, 2, 0);
    axi_read(1'b0, 30'h3FFFC, 1, 3'd2, 1'b0);
    axi_read(1'b0, 30'h0, 0, 3'd2, 1'b0);
    check("wrap_const", 64'(last_rdata), 64'h600DCAFE);

    // Randomized bursts, upper address bits random
    for (int t = 0; t < 15; t++) begin
      a   = (30'($urandom) & 30'h3FFC0000) | (30'($urandom_range(63)) << 2) | 30'h800;
      len = $urandom_range(7);
      nb  = ($urandom_range(4) == 0) ? $urandom_range(1, 9) : len + 1;
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = ($urandom_range(2) == 0) ? 4'($urandom) : 4'hF;
      end
      axi_write(1'($urandom), a, len, 3'd2, nb, $urandom_range(3));
      axi_read(1'($urandom), a, len, 3'd2, 1'b0);
    end

    // Reset in the middle of a 4-beat read
    axi_read(1'b1, 30'h100, 3, 3'd2, 1'b1);
    @(posedge clk); #1;
    check("midrd_rvalid_before", 64'(s_axi.rvalid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrd_rvalid", 64'(s_axi.rvalid), 64'd0);
    check("midrd_arready", 64'(s_axi.arready), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    axi_read(1'b0, 30'h100, 3, 3'd2, 1'b0);
    check("after_reset_read", 64'(last_rdata), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
